pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//   Parametrised program-counter unit for the fetch stage. Holds the current PC,
//   selects the next PC (sequential, branch, jump, call, return) and supports stall.
//   Call/return prediction comes from an optional circular return-address stack (RAS).
//   Drives the instruction-memory address. Branch/jump decisions come from decode/execute.
// PARAMETERS
//   WIDTH      32      PC width in bits
//   RESET_VEC  0       PC value loaded on clr (WIDTH bits)
//   STEP       4       sequential increment; power of 2, >=1
//   RAS_DEPTH  4       RAS entries; power of 2, 2..16 (used only with PC_RAS_EN)
// PORTS
//   clk         in   1      clock, rising edge
//   clr         in   1      asynchronous, active-high reset
//   en          in   1      1 = advance PC this cycle; 0 = stall (hold everything)
//   br_taken    in   1      conditional branch taken
//   br_target   in   WIDTH  branch target
//   jmp         in   1      unconditional jump
//   jmp_target  in   WIDTH  jump/call target
//   call        in   1      call: push return address, go to jmp_target
//   ret         in   1      return: pop RAS, go to popped address
//   pc_out      out  WIDTH  current PC (registered)
//   pc_plus     out  WIDTH  pc_out + STEP (combinational, wraps mod 2^WIDTH)
//   misalign    out  1      registered 1-cycle pulse: last redirect target was unaligned
//   ras_empty   out  1      RAS holds 0 entries
//   ras_full    out  1      RAS holds RAS_DEPTH entries
// BEHAVIOUR
//   - clr (async): pc_out=RESET_VEC, misalign=0, RAS count=0, ras_empty=1, ras_full=0.
//     The RAS pointer resets to 0. Entry contents are don't-care.
//   - clr asserted mid-operation overrides every input immediately. First update is the
//     first rising edge after clr falls.
//   - en=0: pc_out, RAS and misalign hold. All control inputs are ignored (no push/pop).
//   - en=1, next-PC priority (highest first): ret > call > jmp > br_taken > sequential.
//     ret:   pc_out <= RAS top; pop (count-1)
//     call:  pc_out <= jmp_target; push pc_plus (count+1)
//     jmp:   pc_out <= jmp_target
//     br:    pc_out <= br_target
//     else:  pc_out <= pc_plus
//   - Latency: one clock from input sample to pc_out. No bubble is inserted.
//   - Simultaneous call+ret: ret wins. There is no push, and the pop happens.
//   - ret with RAS empty: pc_out <= pc_plus. Count stays 0. misalign is not affected.
//   - call with RAS full: push overwrites the oldest entry (circular).
//     Count stays RAS_DEPTH, ras_full stays 1.
//   - Alignment: redirect targets (br/jmp/call/ret) have low log2(STEP) bits forced to 0.
//     misalign<=1 for one cycle if the chosen target had any of those bits set, else 0.
//     Sequential updates always give misalign<=0.
//   - Wrap-around: pc_plus of 2^WIDTH-STEP is 0. No flag is raised.
//   - RAS_DEPTH=2: push/pop pointer arithmetic is mod RAS_DEPTH.
// CONFIGURATION
//   PC_RAS_EN defined: RAS is built as described above.
//   PC_RAS_EN undefined: no RAS storage is built.
//     call behaves as jmp. ret is ignored (falls through to lower priorities).
//     ras_empty is tied 1, ras_full is tied 0. RAS_DEPTH is unused.
// TESTING (WIDTH=32, STEP=4, RESET_VEC=32'h100, RAS_DEPTH=4, PC_RAS_EN defined)
//   1. Reset then en=1 for 3 cycles -> pc_out 100,104,108,10C. Pulse clr mid-run ->
//      pc_out=100 immediately, with no clock edge.
//   2. en=0 for 2 cycles with br_taken=1, br_target=200 -> pc_out holds.
//      en=1 next -> pc_out=200.
//   3. At pc=104: call jmp_target=300 -> pc=300, ras_empty=0. Then 2 sequential cycles,
//      then ret -> pc=108, ras_empty=1.
//   4. 5 calls from pcs 100,200,300,400,500 -> ras_full=1. 4 rets -> pc 504,404,304,204.
//      5th ret (empty) -> pc=208.
//   5. Same cycle ret=1, call=1, jmp=1, br_taken=1 with RAS top=110 -> pc=110, no push.
//      br_target=203 alone -> pc=200, misalign=1 for exactly one cycle.
//   6. pc=FFFFFFFC sequential -> pc=0, pc_plus=4. With PC_RAS_EN undefined:
//      call to 300 -> pc=300. ret -> pc=304, ras_empty=1.

Source files
------------

// File: rtl/pc_unit_if.sv
// pc_unit_if
//   Bundles the fetch-stage control inputs and the PC outputs of pc_unit.
//   master : decode/execute side. It drives the redirect controls and reads the PC.
//   slave  : pc_unit itself.
//   Signals:
//     en, br_taken, br_target, jmp, jmp_target, call, ret   (master -> slave)
//     pc_out, pc_plus, misalign, ras_empty, ras_full        (slave -> master)
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jmp;
  logic [WIDTH-1:0] jmp_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus;
  logic             misalign;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output en, br_taken, br_target, jmp, jmp_target, call, ret,
    input  pc_out, pc_plus, misalign, ras_empty, ras_full
  );

  modport slave (
    input  en, br_taken, br_target, jmp, jmp_target, call, ret,
    output pc_out, pc_plus, misalign, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit
//   Program-counter unit for the fetch stage. It holds the current PC and picks
//   the next one. The choices, highest priority first, are return > call > jump
//   > branch > sequential. While en is low the unit stalls.
//   Optional feature macro: PC_RAS_EN. When it is defined, a circular
//   return-address stack is built. When it is undefined, call acts as a jump,
//   ret is ignored, ras_empty is tied to 1 and ras_full is tied to 0.
//   Ports:
//     clk  : clock, rising edge
//     clr  : asynchronous, active-high reset
//     bus  : pc_unit_if.slave (controls in; pc_out/pc_plus/misalign/RAS flags out)
//   Parameters: WIDTH, RESET_VEC, STEP (power of 2), RAS_DEPTH (power of 2, 2..16)
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     clr,
  pc_unit_if.slave bus
);

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LOW_MASK = STEP_W - 1'b1;

  logic [WIDTH-1:0] pc_q;
  logic             mis_q;
  logic [WIDTH-1:0] tgt;
  logic             redirect;
  logic             ras_push;
  logic             ras_pop;
  logic             ret_act;
  logic [WIDTH-1:0] ras_top;

  assign bus.pc_out   = pc_q;
  assign bus.pc_plus  = pc_q + STEP_W;
  assign bus.misalign = mis_q;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [PW-1:0]    ptr_dec;
  logic [PW:0]      ras_cnt;

  // ras_ptr points at the next free slot. Because the depth is a power of 2,
  // the pointer wraps by itself. A push into a full stack therefore lands on
  // the oldest entry.
  assign ptr_dec       = ras_ptr - 1'b1;
  assign ras_top       = ras_mem[ptr_dec];
  assign ret_act       = bus.ret;
  assign ras_pop       = bus.en && bus.ret && (ras_cnt != '0);
  assign ras_push      = bus.en && bus.call && !bus.ret;
  assign bus.ras_empty = (ras_cnt == '0);
  assign bus.ras_full  = (ras_cnt == CNT_FULL);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_pop) begin
      ras_ptr <= ptr_dec;
      ras_cnt <= ras_cnt - 1'b1;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + 1'b1;
    end
  end

  // Entry contents do not matter after reset, so the storage has no reset.
  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_ptr] <= bus.pc_plus;
  end
`else
  logic unused_noras;

  assign unused_noras  = bus.ret | (RAS_DEPTH > 0);
  assign ret_act       = 1'b0;
  assign ras_pop       = 1'b0;
  assign ras_push      = 1'b0;
  assign ras_top       = '0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
`endif

  // A ret on an empty stack still wins priority. It simply falls back to pc_plus.
  always_comb begin
    tgt      = bus.pc_plus;
    redirect = 1'b0;
    if (ret_act) begin
      if (ras_pop) begin
        tgt      = ras_top;
        redirect = 1'b1;
      end
    end else if (bus.call || bus.jmp) begin
      tgt      = bus.jmp_target;
      redirect = 1'b1;
    end else if (bus.br_taken) begin
      tgt      = bus.br_target;
      redirect = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q  <= RESET_VEC;
      mis_q <= 1'b0;
    end else if (bus.en) begin
      pc_q  <= redirect ? (tgt & ~LOW_MASK) : tgt;
      mis_q <= redirect && ((tgt & LOW_MASK) != '0);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        mis;
    logic        emp;
    logic        full;
  } exp_t;

  logic clk;
  logic clr;
  exp_t q[$];
  int   n_chk;
  int   n_err;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH    (32),
    .RESET_VEC(32'h100),
    .STEP     (4),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic drv(input logic e, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic c,
                     input logic r, input string nm, input logic [31:0] epc,
                     input logic emis, input logic eemp, input logic efull);
    exp_t x;
    @(negedge clk);
    bus.en = e; bus.br_taken = b; bus.br_target = bt;
    bus.jmp = j; bus.jmp_target = jt; bus.call = c; bus.ret = r;
    x.nm = nm; x.pc = epc; x.mis = emis; x.emp = eemp; x.full = efull;
    q.push_back(x);
  endtask

  task automatic sq(input string nm, input logic [31:0] epc, input logic eemp, input logic efull);
    drv(1, 0, 0, 0, 0, 0, 0, nm, epc, 0, eemp, efull);
  endtask

  // Monitor: after each rising edge, compare the DUT outputs with the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".pc"},   bus.pc_out,           e.pc);
        chk({e.nm, ".mis"},  32'(bus.misalign),    32'(e.mis));
        chk({e.nm, ".emp"},  32'(bus.ras_empty),   32'(e.emp));
        chk({e.nm, ".full"}, 32'(bus.ras_full),    32'(e.full));
      end
    end
  end

  initial begin
    n_chk = 0; n_err = 0;
    clr = 1'b1;
    bus.en = 0; bus.br_taken = 0; bus.br_target = 0; bus.jmp = 0;
    bus.jmp_target = 0; bus.call = 0; bus.ret = 0;
    #2;
    chk("rst.pc", bus.pc_out, 32'h100);
    chk("rst.mis", 32'(bus.misalign), 0);
    chk("rst.emp", 32'(bus.ras_empty), 1);
    chk("rst.full", 32'(bus.ras_full), 0);
    @(negedge clk);
    clr = 1'b0;

    // 1: sequential run, then a mid-cycle async clear
    sq("seq1", 32'h104, 1, 0);
    sq("seq2", 32'h108, 1, 0);
    sq("seq3", 32'h10C, 1, 0);
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    chk("clr_mid.pc", bus.pc_out, 32'h100);
    @(negedge clk);
    clr = 1'b0;
    bus.en = 0;

    // 2: stall ignores a taken branch
    drv(0, 1, 32'h200, 0, 0, 0, 0, "stall1", 32'h100, 0, 1, 0);
    drv(0, 1, 32'h200, 0, 0, 0, 0, "stall2", 32'h100, 0, 1, 0);
    drv(1, 1, 32'h200, 0, 0, 0, 0, "br", 32'h200, 0, 1, 0);

    // 3: call and return
    drv(1, 0, 0, 1, 32'h104, 0, 0, "jmp104", 32'h104, 0, 1, 0);
    drv(1, 0, 0, 0, 32'h300, 1, 0, "call300", 32'h300, 0, !RAS, 0);
    sq("c_seq1", 32'h304, !RAS, 0);
    sq("c_seq2", 32'h308, !RAS, 0);
    drv(1, 0, 0, 0, 0, 0, 1, "ret", RAS ? 32'h108 : 32'h30C, 0, 1, 0);

    // 4: overfill the stack, then drain it past empty
    drv(1, 0, 0, 1, 32'h100, 0, 0, "jmp100", 32'h100, 0, 1, 0);
    drv(1, 0, 0, 0, 32'h200, 1, 0, "call_a", 32'h200, 0, !RAS, 0);
    drv(1, 0, 0, 0, 32'h300, 1, 0, "call_b", 32'h300, 0, !RAS, 0);
    drv(1, 0, 0, 0, 32'h400, 1, 0, "call_c", 32'h400, 0, !RAS, 0);
    drv(1, 0, 0, 0, 32'h500, 1, 0, "call_d", 32'h500, 0, !RAS, RAS);
    drv(1, 0, 0, 0, 32'h600, 1, 0, "call_e", 32'h600, 0, !RAS, RAS);
    drv(1, 0, 0, 0, 0, 0, 1, "ret_a", RAS ? 32'h504 : 32'h604, 0, !RAS, 0);
    drv(1, 0, 0, 0, 0, 0, 1, "ret_b", RAS ? 32'h404 : 32'h608, 0, !RAS, 0);
    drv(1, 0, 0, 0, 0, 0, 1, "ret_c", RAS ? 32'h304 : 32'h60C, 0, !RAS, 0);
    drv(1, 0, 0, 0, 0, 0, 1, "ret_d", RAS ? 32'h204 : 32'h610, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 1, "ret_empty", RAS ? 32'h208 : 32'h614, 0, 1, 0);

    // 5: all redirects at once, then misaligned targets
    drv(1, 0, 0, 1, 32'h10C, 0, 0, "jmp10C", 32'h10C, 0, 1, 0);
    drv(1, 0, 0, 0, 32'h400, 1, 0, "call400", 32'h400, 0, !RAS, 0);
    drv(1, 1, 32'h600, 1, 32'h500, 1, 1, "all4", RAS ? 32'h110 : 32'h500, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 1, "nopush", RAS ? 32'h114 : 32'h504, 0, 1, 0);
    drv(1, 1, 32'h203, 0, 0, 0, 0, "br_mis", 32'h200, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, "mis_hold", 32'h200, 1, 1, 0);
    sq("mis_clear", 32'h204, 1, 0);
    drv(1, 0, 0, 0, 32'h303, 1, 0, "call_mis", 32'h300, 1, !RAS, 0);
    drv(1, 0, 0, 0, 0, 0, 1, "ret_aft_mis", RAS ? 32'h208 : 32'h304, 0, 1, 0);

    // 6: wrap-around
    drv(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, "jmp_top", 32'hFFFF_FFFC, 0, 1, 0);
    @(posedge clk);
    #2;
    chk("wrap.pc_plus", bus.pc_plus, 32'h0);
    sq("wrap", 32'h0, 1, 0);
    @(posedge clk);
    #2;
    chk("wrap.pc_plus4", bus.pc_plus, 32'h4);

    @(negedge clk);
    bus.en = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
